// File: rtl/sobel_window_stream.sv
// Streams raster-order pixels through two line buffers and emits one 3x3
// neighbourhood per pixel, with zero or replicate substitution at the image border.
module sobel_window_stream #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 96,
    parameter int PIX_W       = 8,
    parameter int BORDER_MODE = 0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix_0,
    output logic [PIX_W-1:0] pix_1,
    output logic [PIX_W-1:0] pix_2,
    output logic [PIX_W-1:0] pix_3,
    output logic [PIX_W-1:0] pix_4,
    output logic [PIX_W-1:0] pix_5,
    output logic [PIX_W-1:0] pix_6,
    output logic [PIX_W-1:0] pix_7,
    output logic [PIX_W-1:0] pix_8,
    output logic             out_edge,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t           state;
    logic [XW-1:0]    in_x, next_x, rd_addr, win_x;
    logic [YW-1:0]    in_y, win_y;
    logic             drain;
    logic             out_free, accept, flush_step, step, produce, x_last;
    logic [PIX_W-1:0] new_pix;

    logic [PIX_W-1:0] lb1 [WIDTH];
    logic [PIX_W-1:0] lb2 [WIDTH];
    logic [PIX_W-1:0] lb1_q, lb2_q;

    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] cur [3][3];
    logic [PIX_W-1:0] sel [9];
    logic [PIX_W-1:0] out_w [9];

    always_comb begin
        out_free   = ~out_valid | out_ready;
        in_ready   = (state == FILL) | ((state == RUN) & out_free);
        accept     = in_valid & in_ready;
        flush_step = (state == FLUSH) & ~drain & out_free;
        step       = accept | flush_step;
        new_pix    = accept ? in_pix : '0;
        produce    = flush_step | (accept & ((state == RUN) |
                     ((in_x == XW'(1)) & (in_y == YW'(1)))));
        x_last     = (in_x == X_LAST);
        next_x     = x_last ? '0 : in_x + XW'(1);
        rd_addr    = step ? next_x : in_x;
    end

    // Reads are prefetched one cycle ahead so the column for the next step is
    // already registered; the read and write addresses never coincide.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1[in_x] <= new_pix;
            lb2[in_x] <= lb1_q;
        end
        lb1_q <= lb1[rd_addr];
        lb2_q <= lb2[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_q;
            win[1][2] <= lb1_q;
            win[2][2] <= new_pix;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            cur[r][0] = win[r][1];
            cur[r][1] = win[r][2];
        end
        cur[0][2] = lb2_q;
        cur[1][2] = lb1_q;
        cur[2][2] = new_pix;
    end

    // Out-of-image taps either read zero or fold onto the centre row/column,
    // which also hides the wrapped-in column from the neighbouring line.
    always_comb begin
        logic [1:0] rs, cs;
        logic       oob;
        sel = '{default: '0};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rs  = 2'(r);
                cs  = 2'(c);
                oob = 1'b0;
                if (c == 0 && win_x == '0)    begin oob = 1'b1; cs = 2'd1; end
                if (c == 2 && win_x == X_LAST) begin oob = 1'b1; cs = 2'd1; end
                if (r == 0 && win_y == '0)    begin oob = 1'b1; rs = 2'd1; end
                if (r == 2 && win_y == Y_LAST) begin oob = 1'b1; rs = 2'd1; end
                sel[r*3+c] = (BORDER_MODE == 0 && oob) ? '0 : cur[rs][cs];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            in_x      <= '0;
            in_y      <= '0;
            win_x     <= '0;
            win_y     <= '0;
            drain     <= 1'b0;
            out_valid <= 1'b0;
            out_edge  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_w     <= '{default: '0};
        end else begin
            if (step) begin
                in_x <= next_x;
                if (accept && x_last)
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
            end

            if (produce) begin
                out_w     <= sel;
                out_x     <= win_x;
                out_y     <= win_y;
                out_edge  <= (win_x == '0) | (win_x == X_LAST) |
                             (win_y == '0) | (win_y == Y_LAST);
                out_valid <= 1'b1;
                if (win_x == X_LAST) begin
                    win_x <= '0;
                    if (win_y == Y_LAST) begin
                        win_y <= '0;
                        drain <= 1'b1;
                    end else begin
                        win_y <= win_y + YW'(1);
                    end
                end else begin
                    win_x <= win_x + XW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                FILL:  if (produce) state <= RUN;
                RUN:   if (accept && x_last && in_y == Y_LAST) state <= FLUSH;
                FLUSH: if (drain && out_valid && out_ready) begin
                    state <= FILL;
                    drain <= 1'b0;
                    in_x  <= '0;
                    in_y  <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign pix_0 = out_w[0];
    assign pix_1 = out_w[1];
    assign pix_2 = out_w[2];
    assign pix_3 = out_w[3];
    assign pix_4 = out_w[4];
    assign pix_5 = out_w[5];
    assign pix_6 = out_w[6];
    assign pix_7 = out_w[7];
    assign pix_8 = out_w[8];

endmodule

// File: tb/tb_sobel_window_stream.sv
// Directed bench for sobel_window_stream on an 8x6 image, pix(x,y) = y*16+x,
// with one zero-border and one replicate-border instance fed the same stream.
module tb_sobel_window_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, out_ready;
    logic [PW-1:0] in_pix;

    logic          in_ready, out_valid, out_edge;
    logic [2:0]    out_x, out_y;
    logic [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

    logic          in_ready_r, out_valid_r, out_edge_r;
    logic [2:0]    out_x_r, out_y_r;
    logic [PW-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    logic [71:0]   win_z, win_r;

    int  tests, fails;
    int  cycle, send_idx, send_limit, exp_idx, accept9_cycle, flush_chk, stall_left;
    bit  wait_first, stall_done, chk_reset_drop;

    always #5 clk = ~clk;

    sobel_window_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .BORDER_MODE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix_0(p0), .pix_1(p1), .pix_2(p2), .pix_3(p3), .pix_4(p4),
        .pix_5(p5), .pix_6(p6), .pix_7(p7), .pix_8(p8),
        .out_edge(out_edge), .out_x(out_x), .out_y(out_y)
    );

    sobel_window_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .BORDER_MODE(1)) dut_rep (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_pix(in_pix),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .pix_0(r0), .pix_1(r1), .pix_2(r2), .pix_3(r3), .pix_4(r4),
        .pix_5(r5), .pix_6(r6), .pix_7(r7), .pix_8(r8),
        .out_edge(out_edge_r), .out_x(out_x_r), .out_y(out_y_r)
    );

    assign win_z = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
    assign win_r = {r0, r1, r2, r3, r4, r5, r6, r7, r8};

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] pixAt(input int x, input int y);
        return 8'(y * 16 + x);
    endfunction

    function automatic logic [71:0] modelWindow(input int mode, input int cx, input int cy);
        logic [71:0] w;
        int          nx, ny;
        bit          oob;
        logic [7:0]  v;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            nx  = cx + (k % 3) - 1;
            ny  = cy + (k / 3) - 1;
            oob = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
            if (nx < 0)  nx = 0;
            if (nx >= W) nx = W - 1;
            if (ny < 0)  ny = 0;
            if (ny >= H) ny = H - 1;
            v = (oob && mode == 0) ? 8'h00 : pixAt(nx, ny);
            w = {w[63:0], v};
        end
        return w;
    endfunction

    task automatic checkWindow();
        int  ex, ey;
        bit  edge_exp;
        ex = (exp_idx % N) % W;
        ey = (exp_idx % N) / W;
        edge_exp = (ex == 0) || (ex == W - 1) || (ey == 0) || (ey == H - 1);
        checkOutput("coord", {out_y, out_x}, {3'(ey), 3'(ex)});
        checkOutput("coord_rep", {out_y_r, out_x_r}, {3'(ey), 3'(ex)});
        checkOutput("rep_valid", out_valid_r, 1'b1);
        checkOutput("win_zero", win_z, modelWindow(0, ex, ey));
        checkOutput("win_rep", win_r, modelWindow(1, ex, ey));
        checkOutput("edge", out_edge, edge_exp);
        checkOutput("edge_rep", out_edge_r, edge_exp);
        if (ex == 0 && ey == 0) begin
            checkOutput("first_zero", win_z, 72'h000000000001001011);
            checkOutput("first_rep", win_r, 72'h000001000001101011);
        end
        if (ex == 3 && ey == 2) begin
            checkOutput("interior_zero", win_z, 72'h121314222324323334);
            checkOutput("interior_rep", win_r, 72'h121314222324323334);
            checkOutput("interior_edge", out_edge, 1'b0);
        end
        if (ex == 7 && ey == 5) begin
            checkOutput("corner_rep_pix8", r8, 8'h57);
            checkOutput("corner_rep_pix2", r2, 8'h47);
        end
        exp_idx++;
    endtask

    // One clock cycle: drive after the rising edge, observe on the falling edge.
    task automatic applyStimulus(input bit valid_en, input bit ready);
        in_valid  = valid_en && (send_idx < send_limit);
        in_pix    = pixAt((send_idx % N) % W, (send_idx % N) / W);
        out_ready = ready;
        @(negedge clk);
        if (chk_reset_drop) begin
            checkOutput("post_reset_valid", out_valid, 1'b0);
            chk_reset_drop = 1'b0;
        end
        if (flush_chk > 0) begin
            checkOutput("flush_in_ready", in_ready, 1'b0);
            flush_chk--;
        end
        if (stall_left > 0) begin
            checkOutput("stall_valid", out_valid, 1'b1);
            checkOutput("stall_hold", win_z, modelWindow(0, (exp_idx % N) % W, (exp_idx % N) / W));
            if (stall_left <= 4) begin
                checkOutput("stall_in_ready", in_ready, 1'b0);
                checkOutput("stall_in_ready_rep", in_ready_r, 1'b0);
            end
            stall_left--;
        end
        if (wait_first && out_valid) begin
            checkOutput("first_valid_latency", 32'(cycle - accept9_cycle), 32'd1);
            wait_first = 1'b0;
        end
        if (in_valid && in_ready) begin
            if (send_idx % N == W + 1) accept9_cycle = cycle;
            if (send_idx % N == N - 1) flush_chk = W + 1;
            send_idx++;
        end
        if (out_valid && out_ready) checkWindow();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        bit rdy;
        tests = 0; fails = 0; cycle = 0;
        send_idx = 0; send_limit = 0; exp_idx = 0;
        accept9_cycle = -100; flush_chk = 0; stall_left = 0;
        wait_first = 1'b0; stall_done = 1'b0; chk_reset_drop = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ctrl", {out_valid, out_edge, out_x, out_y}, '0);
        checkOutput("reset_win", win_z, '0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Two back-to-back frames with a five-cycle output stall in the first.
        $display("[TB] two continuous frames with mid-frame backpressure");
        send_limit = 2 * N;
        wait_first = 1'b1;
        for (int c = 0; c < 1000 && exp_idx < 2 * N; c++) begin
            if (!stall_done && exp_idx == 20) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            rdy = (stall_left == 0);
            applyStimulus(1'b1, rdy);
        end
        checkOutput("total_two_frames", 32'(exp_idx), 32'(2 * N));
        checkOutput("sent_two_frames", 32'(send_idx), 32'(2 * N));

        // Abandon a frame after 20 inputs, then stream a fresh one.
        $display("[TB] reset mid-frame then fresh frame");
        send_idx = 0; send_limit = 20; exp_idx = 0;
        accept9_cycle = -100; wait_first = 1'b1;
        for (int c = 0; c < 200 && send_idx < 20; c++) applyStimulus(1'b1, 1'b1);
        checkOutput("partial_sent", 32'(send_idx), 32'd20);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        send_idx = 0; send_limit = N; exp_idx = 0;
        accept9_cycle = -100; wait_first = 1'b1; chk_reset_drop = 1'b1;
        for (int c = 0; c < 500 && exp_idx < N; c++) applyStimulus(1'b1, 1'b1);
        checkOutput("total_after_reset", 32'(exp_idx), 32'(N));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sobel_window_stream.md
Name: sobel_window_stream

Overview:
- Parametrised successor of the current 3x3 pixel-window fetch stage feeding the Sobel core.
- Replaces the whole-image block-RAM read with a raster-order pixel stream (valid/ready) and two internal line buffers, so image size is not limited by preloaded memory.
- Emits one full 3x3 neighbourhood per image pixel, centre included, with a selectable border policy and an edge flag.
- Sits between the camera/frame source and the Sobel gradient block; one frame = WIDTH*HEIGHT inputs -> WIDTH*HEIGHT windows.

Parameters:
- WIDTH, 128, pixels per line (>=3).
- HEIGHT, 96, lines per frame (>=3).
- PIX_W, 8, bits per pixel.
- BORDER_MODE, 0, out-of-image neighbours: 0 = zero, 1 = replicate nearest edge pixel.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts in_pix this cycle.
- in_pix  in  PIX_W  raster-order pixel, x fastest.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- pix_0..pix_8  out  PIX_W each  window, row-major: 0 = (cx-1,cy-1), 4 = centre, 8 = (cx+1,cy+1).
- out_edge  out  1  centre on first/last row or column.
- out_x  out  clog2(WIDTH)  centre column.
- out_y  out  clog2(HEIGHT)  centre row.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_edge=0, pix_*=0, out_x=out_y=0.
  - Input counters cleared; FSM -> FILL.
  - Line-buffer contents are don't-care; masked by the row counters.
  - Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - Single output register stage.
  - Window data, out_edge, out_x and out_y are held stable while out_valid & ~out_ready.
- FSM:
  - FILL: in_ready=1. Accept pixels, no output, until WIDTH+1 pixels are taken. The window for centre (0,0) is formed when pixel (1,1), index WIDTH+1, is accepted; out_valid rises the next cycle. -> RUN.
  - RUN: in_ready = ~out_valid | out_ready. Each accepted pixel at index n produces the window centred at index n-WIDTH-1, registered one cycle later. After the last pixel (WIDTH-1,HEIGHT-1) is accepted -> FLUSH.
  - FLUSH: in_ready=0. Emits the remaining WIDTH+1 windows, one per cycle when the output stage is free; out-of-image neighbours are substituted. After the window for centre (WIDTH-1,HEIGHT-1) transfers -> FILL with counters at 0. A pixel offered in that same cycle is not accepted.
- Latency: one cycle from the enabling input transfer (or flush step) to out_valid.
- Back-to-back frames have WIDTH+1 flush cycles of in_ready=0 between them.
- Border substitution:
  - A neighbour is out-of-image if cx±1 falls outside [0,WIDTH-1] or cy±1 outside [0,HEIGHT-1].
  - Column wrap must never pull pixels from the adjacent line.
  - BORDER_MODE 0: the neighbour reads as 0.
  - BORDER_MODE 1: the neighbour reads as the pixel at the clamped coordinate.
- out_edge = (cx==0)|(cx==WIDTH-1)|(cy==0)|(cy==HEIGHT-1); independent of BORDER_MODE.
- Line buffers: two WIDTH x PIX_W memories, one read plus one write per cycle, inferable as block RAM. Addressed by the input column counter; advance only on input transfer or flush step.
- No arithmetic on pixel values; widths pass through unchanged.
- Exactly WIDTH*HEIGHT output transfers per frame. No window is duplicated or dropped under any out_ready pattern.

Test Plan:
(WIDTH=8, HEIGHT=6, PIX_W=8, image pix(x,y) = y*16+x, out_ready=1 unless stated.)
1. Zero mode, first window:
   - out_x=0, out_y=0, out_edge=1.
   - pix_0,1,2,3,6 = 0; pix_4=0x00, pix_5=0x01, pix_7=0x10, pix_8=0x11.
   - out_valid first high the cycle after input index 9 is accepted.
2. Interior window centre (3,2), either mode:
   - pix_0..8 = 0x12,0x13,0x14,0x22,0x23,0x24,0x32,0x33,0x34; out_edge=0.
3. Replicate mode:
   - Centre (0,0): pix_0..8 = 00,00,01,00,00,01,10,10,11.
   - Centre (7,5): pix_8=0x57, pix_2=0x47.
4. Backpressure: hold out_ready=0 for 5 cycles mid-frame.
   - in_ready=0 from the second stalled cycle.
   - Outputs held constant throughout the stall.
   - Exactly 48 windows per frame, coordinates in raster order.
5. Flush and back-to-back frames: stream two frames continuously.
   - 9 cycles of in_ready=0 after the 48th input of each frame.
   - 96 windows total; frame 2's first window equals scenario 1.
6. Reset mid-frame: rst for 1 cycle after 20 inputs.
   - out_valid=0 the next cycle.
   - A fresh frame yields 48 correct windows starting with scenario 1 values.
